pe_result_writeback: RTL
========================

PE_RESULT_WRITEBACK -- requirements
Module: pe_result_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width in bits (FP16/BF16).
REQ-002 Parameter VECTOR_WIDTH, default 16, elements per result vector.
REQ-003 Parameter FIFO_DEPTH, default 4, result vectors buffered; power of two, at least 2.
REQ-004 Parameter BEAT_BYTES is derived as DATA_WIDTH*VECTOR_WIDTH/8 (32 at defaults), the address increment per beat.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port valid_in, input, 1, PE result vector present (driven by PE valid_out).
REQ-008 Port result_i, input, array [VECTOR_WIDTH-1:0] of DATA_WIDTH, PE result vector.
REQ-009 Port ready_out, output, 1, block can accept a vector this cycle.
REQ-010 Port start_i, input, 1, one-cycle pulse loading base address and clearing counters.
REQ-011 Port base_addr_i, input, 32, byte address of first beat, sampled on an accepted start_i.
REQ-012 Port mem_req_o, output, 1, write request to memory.
REQ-013 Port mem_addr_o, output, 32, byte address of current beat.
REQ-014 Port mem_data_o, output, DATA_WIDTH*VECTOR_WIDTH, packed beat; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 Port mem_ack_i, input, 1, memory accepted the current beat.
REQ-016 Port level_o, output, $clog2(FIFO_DEPTH)+1, vectors currently buffered.
REQ-017 Port beat_cnt_o, output, 16, beats written since last accepted start_i.
REQ-018 Port busy_o, output, 1, high when FSM is not IDLE or FIFO is non-empty.
REQ-019 Port drop_o, output, 1, sticky flag: a vector was offered while ready_out was low.

Function
REQ-020 A vector SHALL be accepted on a rising edge where valid_in and ready_out are both high; it is written into the FIFO tail.
REQ-021 ready_out SHALL equal (level_o < FIFO_DEPTH) and SHALL NOT depend combinationally on mem_ack_i.
REQ-022 valid_in high while ready_out is low SHALL discard the vector and set drop_o until the next accepted start_i or reset.
REQ-023 The FSM SHALL have two states: IDLE and REQ; mem_req_o SHALL be high exactly when the state is REQ.
REQ-024 IDLE->REQ SHALL occur on the edge where the FIFO is non-empty; a vector accepted at edge t gives mem_req_o high after edge t+1.
REQ-025 In REQ, mem_data_o SHALL present the FIFO head and mem_addr_o the current address; both SHALL hold stable until mem_ack_i.
REQ-026 mem_ack_i high in REQ SHALL pop the head, add BEAT_BYTES to the address (modulo 2^32), and increment beat_cnt_o (modulo 2^16).
REQ-027 After an ack, the FSM SHALL stay in REQ if at least one vector remains, otherwise go to IDLE; back-to-back acks SHALL give one beat per cycle.
REQ-028 Push and pop on the same edge SHALL leave level_o unchanged and preserve FIFO order; when full, the pop SHALL free a slot for the next cycle only.
REQ-029 mem_ack_i while in IDLE SHALL be ignored.
REQ-030 start_i SHALL be accepted only when busy_o is low: it loads base_addr_i into the address and clears beat_cnt_o and drop_o; otherwise it is ignored.
REQ-031 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by level_o.

Reset
REQ-032 While rst_n is low: state IDLE, FIFO empty, mem_req_o 0, mem_addr_o 0, mem_data_o 0, level_o 0, beat_cnt_o 0, busy_o 0, drop_o 0, ready_out 1.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered vectors and drop mem_req_o asynchronously.

Verification
REQ-034 Single vector: start_i with base 0x1000, one vector with element i = i -> mem_req_o two edges later, addr 0x1000, data element i = i; ack -> beat_cnt_o 1, idle.
REQ-035 Burst with ack always high: four consecutive vectors -> addresses 0x1000, 0x1020, 0x1040, 0x1060 on consecutive cycles, in order, beat_cnt_o 4.
REQ-036 Backpressure: ack held low, six vectors offered -> ready_out low after four, level_o 4, drop_o 1, only the first four written, in order, once ack resumes.
REQ-037 Wrap: base 0xFFFFFFE0, two vectors -> addresses 0xFFFFFFE0 then 0x00000000.
REQ-038 start_i while busy -> ignored (address and count continue); reset mid-REQ -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pe_result_writeback.sv
// PE result writeback: buffers PE result vectors in a small FIFO and streams
// them to memory as one packed beat per vector at consecutive byte addresses.
module pe_result_writeback #(
    parameter int DATA_WIDTH   = 16,
    parameter int VECTOR_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          valid_in,
    input  logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0]       result_i,
    output logic                                          ready_out,
    input  logic                                          start_i,
    input  logic [31:0]                                   base_addr_i,
    output logic                                          mem_req_o,
    output logic [31:0]                                   mem_addr_o,
    output logic [DATA_WIDTH*VECTOR_WIDTH-1:0]            mem_data_o,
    input  logic                                          mem_ack_i,
    output logic [$clog2(FIFO_DEPTH):0]                   level_o,
    output logic [15:0]                                   beat_cnt_o,
    output logic                                          busy_o,
    output logic                                          drop_o
);

    localparam int BEAT_BYTES = DATA_WIDTH * VECTOR_WIDTH / 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    typedef logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic {IDLE, REQ} state_t;

    state_t           state_q, state_d;
    vec_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      addr_q;
    logic [15:0]      beat_cnt_q;
    logic             drop_q;
    logic             push, pop, start_ok;

    // Handshake qualifiers; ready depends only on the registered level, never on mem_ack_i.
    assign ready_out = (level_q < LVL_W'(FIFO_DEPTH));
    assign push      = valid_in & ready_out;
    assign pop       = (state_q == REQ) & mem_ack_i;
    assign busy_o    = (state_q != IDLE) | (level_q != '0);
    assign start_ok  = start_i & ~busy_o;

    // Output mapping; data is gated so it reads zero whenever no request is pending.
    assign mem_req_o  = (state_q == REQ);
    assign mem_addr_o = addr_q;
    assign mem_data_o = (state_q == REQ) ? fifo_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign beat_cnt_o = beat_cnt_q;
    assign drop_o     = drop_q;

    // Next FIFO occupancy: simultaneous push and pop cancel out.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state logic: request while anything is buffered, return to IDLE on the last ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (level_q != '0) state_d = REQ;
            REQ:     if (pop && (level_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential blocks use non-blocking '<=' so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FIFO storage; written at the tail on every accepted vector.
    // NOTE: the storage array has no reset; emptiness is tracked by level_q and unread slots are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= result_i;
    end

    // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Address, beat counter and sticky drop flag; start is honoured only when idle and empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            beat_cnt_q <= '0;
            drop_q     <= 1'b0;
        end else if (start_ok) begin
            addr_q     <= base_addr_i;
            beat_cnt_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            if (pop) begin
                addr_q     <= addr_q + 32'(BEAT_BYTES);
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
            if (valid_in && !ready_out) drop_q <= 1'b1;
        end
    end

endmodule
